// File: rtl/ram_bank_arbiter.sv
// ram_bank_arbiter: two-requester round-robin arbiter in front of a 2-bank x 8-entry sync-read RAM.
// Define RAM_ARB_CNT_EN to add the saturating conflict_cnt output.
module ram_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             we_a,
    input  logic [3:0]       addr_a,
    input  logic [WIDTH-1:0] din_a,
    output logic             gnt_a,
    output logic             rvalid_a,
    output logic [WIDTH-1:0] dout_a,
    input  logic             req_b,
    input  logic             we_b,
    input  logic [3:0]       addr_b,
    input  logic [WIDTH-1:0] din_b,
    output logic             gnt_b,
    output logic             rvalid_b,
    output logic [WIDTH-1:0] dout_b
`ifdef RAM_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);
    logic [WIDTH-1:0] r_mem [16];
    logic             r_prio;
    logic             r_rvalid_a;
    logic             r_rvalid_b;
    logic [WIDTH-1:0] r_dout_a;
    logic [WIDTH-1:0] r_dout_b;
    logic             w_conflict;
    logic             w_rd_a;
    logic             w_rd_b;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign w_conflict = req_a & req_b & (addr_a[3] == addr_b[3]);
    // rst_n gates the grants so nothing is accepted while reset is held
    assign gnt_a      = rst_n & req_a & ~(w_conflict & r_prio);
    assign gnt_b      = rst_n & req_b & ~(w_conflict & ~r_prio);
    assign w_rd_a     = gnt_a & ~we_a;
    assign w_rd_b     = gnt_b & ~we_b;
    assign rvalid_a   = r_rvalid_a;
    assign rvalid_b   = r_rvalid_b;
    assign dout_a     = r_dout_a;
    assign dout_b     = r_dout_b;

    always_ff @(posedge clk) begin
        if (gnt_a && we_a) r_mem[addr_a] <= din_a;
        if (gnt_b && we_b) r_mem[addr_b] <= din_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio     <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_dout_a   <= '0;
            r_dout_b   <= '0;
        end else begin
            if (w_conflict) r_prio <= ~r_prio;
            r_rvalid_a <= w_rd_a;
            r_rvalid_b <= w_rd_b;
            if (w_rd_a) r_dout_a <= r_mem[addr_a];
            if (w_rd_b) r_dout_b <= r_mem[addr_b];
        end
    end

`ifdef RAM_ARB_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    assign conflict_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (w_conflict && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_ram_bank_arbiter.sv
// tb_ram_bank_arbiter: directed scoreboard bench for ram_bank_arbiter.
module tb_ram_bank_arbiter;
    localparam int W  = 8;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [3:0]   addr_a = '0, addr_b = '0;
    logic [W-1:0] din_a = '0, din_b = '0;
    logic         gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [W-1:0] dout_a, dout_b;
`ifdef RAM_ARB_CNT_EN
    logic [CW-1:0] conflict_cnt;
`endif

    int           vectors = 0;
    int           miscompares = 0;
    int           n_gnt_a = 0;
    int           n_gnt_b = 0;
    logic [W-1:0] mem_m [16];
    logic [W-1:0] q_a [$];
    logic [W-1:0] q_b [$];
    logic         exp_rv_a = 1'b0;
    logic         exp_rv_b = 1'b0;

    ram_bank_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .dout_a(dout_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
`ifdef RAM_ARB_CNT_EN
        .conflict_cnt(conflict_cnt),
`endif
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .dout_b(dout_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv_a(input logic r, input logic w, input logic [3:0] a, input logic [W-1:0] d);
        req_a = r; we_a = w; addr_a = a; din_a = d;
    endtask

    task automatic drv_b(input logic r, input logic w, input logic [3:0] a, input logic [W-1:0] d);
        req_b = r; we_b = w; addr_b = a; din_b = d;
    endtask

    // One clock: check last cycle's read returns and this cycle's grants, then model the edge.
    task automatic cyc(input logic ga, input logic gb);
        logic         wa, wb;
        logic [3:0]   aa, ab;
        logic [W-1:0] da, db;
        @(negedge clk);
        chk("rvalid_a", {31'd0, rvalid_a}, {31'd0, exp_rv_a});
        chk("rvalid_b", {31'd0, rvalid_b}, {31'd0, exp_rv_b});
        if (exp_rv_a) chk("dout_a", {24'd0, dout_a}, {24'd0, q_a.pop_front()});
        if (exp_rv_b) chk("dout_b", {24'd0, dout_b}, {24'd0, q_b.pop_front()});
        chk("gnt_a", {31'd0, gnt_a}, {31'd0, ga});
        chk("gnt_b", {31'd0, gnt_b}, {31'd0, gb});
        n_gnt_a += int'(gnt_a);
        n_gnt_b += int'(gnt_b);
        wa = we_a; wb = we_b; aa = addr_a; ab = addr_b; da = din_a; db = din_b;
        @(posedge clk);
        exp_rv_a = ga & ~wa;
        exp_rv_b = gb & ~wb;
        if (exp_rv_a) q_a.push_back(mem_m[aa]);
        if (exp_rv_b) q_b.push_back(mem_m[ab]);
        if (ga && wa) mem_m[aa] = da;
        if (gb && wb) mem_m[ab] = db;
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt_a", {31'd0, gnt_a}, 32'd0);
        chk("rst_gnt_b", {31'd0, gnt_b}, 32'd0);
        chk("rst_rvalid_a", {31'd0, rvalid_a}, 32'd0);
        chk("rst_rvalid_b", {31'd0, rvalid_b}, 32'd0);
        chk("rst_dout_a", {24'd0, dout_a}, 32'd0);
        chk("rst_dout_b", {24'd0, dout_b}, 32'd0);
`ifdef RAM_ARB_CNT_EN
        chk("rst_cnt", {28'd0, conflict_cnt}, 32'd0);
`endif
        drv_a(0, 0, 4'h0, '0);
        drv_b(0, 0, 4'h0, '0);
        exp_rv_a = 1'b0;
        exp_rv_b = 1'b0;
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        do_reset();
        cyc(0, 0);
        cyc(0, 0);
        // parallel banks: two writes, then crossed reads
        drv_a(1, 1, 4'h3, 8'h5A); drv_b(1, 1, 4'hB, 8'hC3); cyc(1, 1);
        drv_a(1, 0, 4'hB, '0);    drv_b(1, 0, 4'h3, '0);    cyc(1, 1);
        drv_a(1, 1, 4'h2, 8'h22); drv_b(1, 0, 4'hB, '0);    cyc(1, 1);
        drv_a(1, 0, 4'h2, '0);    drv_b(0, 0, 4'h0, '0);    cyc(1, 0);
        drv_a(0, 0, 4'h0, '0);    cyc(0, 0);
        cyc(0, 0);
        // same-bank conflict
        do_reset();
        drv_a(1, 1, 4'h1, 8'h11); drv_b(1, 0, 4'h2, '0); cyc(1, 0);
        drv_a(0, 0, 4'h0, '0); cyc(0, 1);
        drv_b(0, 0, 4'h0, '0); cyc(0, 0);
`ifdef RAM_ARB_CNT_EN
        chk("cnt_one", {28'd0, conflict_cnt}, 32'd1);
`endif
        cyc(0, 0);
        // round-robin on bank 1
        do_reset();
        n_gnt_a = 0;
        n_gnt_b = 0;
        drv_a(1, 0, 4'hB, '0); drv_b(1, 1, 4'hC, 8'h40);
        for (int i = 0; i < 6; i++) begin
            cyc(i % 2 == 0, i % 2 == 1);
            if (i % 2 == 1) din_b = 8'h41 + 8'(i);
        end
        chk("rr_cnt_a", n_gnt_a, 32'd3);
        chk("rr_cnt_b", n_gnt_b, 32'd3);
`ifdef RAM_ARB_CNT_EN
        chk("cnt_six", {28'd0, conflict_cnt}, 32'd6);
`endif
        drv_a(1, 0, 4'hC, '0); drv_b(0, 0, 4'h0, '0); cyc(1, 0);
        drv_a(0, 0, 4'h0, '0); cyc(0, 0);
        // reset while a read is granted but not yet clocked
        drv_a(1, 0, 4'h3, '0);
        #1 chk("pre_rst_gnt_a", {31'd0, gnt_a}, 32'd1);
        do_reset();
        cyc(0, 0);
        drv_a(1, 0, 4'h3, '0); cyc(1, 0);
        drv_a(0, 0, 4'h0, '0); cyc(0, 0);
        // long conflict run for counter saturation
        do_reset();
        drv_a(1, 1, 4'h0, 8'hA0); drv_b(1, 1, 4'h1, 8'hB0);
        for (int i = 0; i < 20; i++) begin
            cyc(i % 2 == 0, i % 2 == 1);
`ifdef RAM_ARB_CNT_EN
            if (i == 13) chk("cnt_14", {28'd0, conflict_cnt}, 32'd14);
`endif
        end
`ifdef RAM_ARB_CNT_EN
        chk("cnt_sat", {28'd0, conflict_cnt}, 32'hF);
`endif
        drv_a(1, 0, 4'h0, '0); drv_b(1, 0, 4'h1, '0); cyc(1, 0);
        drv_a(0, 0, 4'h0, '0); cyc(0, 1);
        drv_b(0, 0, 4'h0, '0); cyc(0, 0);
        cyc(0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
